// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 adder datapath.
// Operand unpacking helpers used by the align/add front end.
package fp_pkg;

    localparam int unsigned EXP_N      = 8;
    localparam int unsigned MANTISSA_N = 25;
    localparam int unsigned FRAC_N     = 23;
    localparam int unsigned HIDDEN_BIT = 23;
    localparam int unsigned EXP_MAX    = 255;

    typedef struct packed {
        logic              sign;
        logic [EXP_N-1:0]  exp;
        logic [FRAC_N-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic                sign;
        logic [EXP_N-1:0]    exp;
        logic [HIDDEN_BIT:0] man;
    } unpacked_t;

    // Zero exponent flushes the operand (denormals included) to a signed zero.
    function automatic unpacked_t unpack(input fp32_t w);
        unpacked_t u;
        u.sign = w.sign;
        u.exp  = w.exp;
        u.man  = (w.exp != '0) ? {1'b1, w.frac} : '0;
        return u;
    endfunction

endpackage

// File: rtl/fp_unpack_order.sv
// Combinational unpack of both operands and magnitude ordering.
// Ties in magnitude select operand A as the larger one.
module fp_unpack_order
    import fp_pkg::*;
(
    input  fp32_t               a_i,
    input  fp32_t               b_i,
    output unpacked_t           large_o,
    output logic [HIDDEN_BIT:0] small_man_o,
    output logic [EXP_N-1:0]    exp_diff_o,
    output logic                eff_sub_o
);

    unpacked_t ua;
    unpacked_t ub;
    logic      a_ge;

    assign ua = unpack(a_i);
    assign ub = unpack(b_i);

    always_comb begin
        a_ge        = {ua.exp, ua.man} >= {ub.exp, ub.man};
        large_o     = a_ge ? ua : ub;
        small_man_o = a_ge ? ub.man : ua.man;
        exp_diff_o  = a_ge ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
        eff_sub_o   = a_i.sign ^ b_i.sign;
    end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage align/add front end of the binary32 adder: unpack/order, then align and add/sub.
// Produces a raw 25-bit magnitude for the normalizer; valid/ready with backpressure.
module fp_align_add #(
    parameter int unsigned MANTISSA_N = 25,
    parameter int unsigned EXP_N      = 8,
    parameter int unsigned WORD_N     = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [WORD_N-1:0]     aIn,
    input  logic [WORD_N-1:0]     bIn,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [MANTISSA_N-1:0] sumMantissa,
    output logic [EXP_N-1:0]      sumExp,
    output logic                  sumSign,
    output logic                  shiftRight,
    output logic                  outValid,
    input  logic                  outReady
);
    import fp_pkg::*;

    logic                s1_adv;
    logic                s2_adv;

    unpacked_t           large_d;
    logic [HIDDEN_BIT:0] small_man_d;
    logic [EXP_N-1:0]    exp_diff_d;
    logic                eff_sub_d;

    logic                s1_valid_q;
    unpacked_t           s1_large_q;
    logic [HIDDEN_BIT:0] s1_small_man_q;
    logic [EXP_N-1:0]    s1_exp_diff_q;
    logic                s1_eff_sub_q;

    logic [HIDDEN_BIT:0] aligned;
    logic [MANTISSA_N-1:0] result;
    logic                result_zero;

    logic                  s2_valid_q;
    logic [MANTISSA_N-1:0] s2_man_q;
    logic [EXP_N-1:0]      s2_exp_q;
    logic                  s2_sign_q;

    assign s2_adv  = !s2_valid_q || outReady;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign inReady = s1_adv;

    fp_unpack_order u_unpack_order (
        .a_i         (fp32_t'(aIn)),
        .b_i         (fp32_t'(bIn)),
        .large_o     (large_d),
        .small_man_o (small_man_d),
        .exp_diff_o  (exp_diff_d),
        .eff_sub_o   (eff_sub_d)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            s1_valid_q     <= 1'b0;
            s1_large_q     <= '0;
            s1_small_man_q <= '0;
            s1_exp_diff_q  <= '0;
            s1_eff_sub_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q     <= inValid;
            s1_large_q     <= large_d;
            s1_small_man_q <= small_man_d;
            s1_exp_diff_q  <= exp_diff_d;
            s1_eff_sub_q   <= eff_sub_d;
        end
    end

    // Truncating alignment: bits shifted past the LSB are simply lost.
    always_comb begin
        aligned = '0;
        if (s1_exp_diff_q < EXP_N'(HIDDEN_BIT + 1)) begin
            aligned = s1_small_man_q >> s1_exp_diff_q;
        end
        if (s1_eff_sub_q) begin
            result = {1'b0, s1_large_q.man} - {1'b0, aligned};
        end else begin
            result = {1'b0, s1_large_q.man} + {1'b0, aligned};
        end
        result_zero = (result == '0);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            s2_valid_q <= 1'b0;
            s2_man_q   <= '0;
            s2_exp_q   <= '0;
            s2_sign_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            s2_man_q   <= result;
            s2_exp_q   <= result_zero ? '0 : s1_large_q.exp;
            s2_sign_q  <= result_zero ? 1'b0 : s1_large_q.sign;
        end
    end

    assign outValid    = s2_valid_q;
    assign sumMantissa = s2_man_q;
    assign sumExp      = s2_exp_q;
    assign sumSign     = s2_sign_q;
    assign shiftRight  = s2_man_q[MANTISSA_N-1];

endmodule

// File: tb/tb_fp_align_add.sv
// Self-checking bench for fp_align_add: directed vectors, random streams with
// backpressure against an arithmetic reference model, and asynchronous reset.
module tb_fp_align_add;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] aIn = '0;
    logic [31:0] bIn = '0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic        inReady;
    logic [24:0] sumMantissa;
    logic [7:0]  sumExp;
    logic        sumSign;
    logic        shiftRight;
    logic        outValid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [24:0] man;
        logic [7:0]  exp;
        logic        sign;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [24:0] man;
        logic [7:0]  e;
        logic        s;
    } vec_t;

    res_t sb[$];

    fp_align_add #(
        .MANTISSA_N (25),
        .EXP_N      (8),
        .WORD_N     (32)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .aIn         (aIn),
        .bIn         (bIn),
        .inValid     (inValid),
        .inReady     (inReady),
        .sumMantissa (sumMantissa),
        .sumExp      (sumExp),
        .sumSign     (sumSign),
        .shiftRight  (shiftRight),
        .outValid    (outValid),
        .outReady    (outReady)
    );

    always #5 clock = ~clock;

    // Reference: magnitudes as plain integers, alignment as integer division.
    function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        int unsigned ea, eb, ma, mb, el, es, ml, ms, al, diff, val;
        bit          a_big, sl;
        ea = a[30:23];
        eb = b[30:23];
        ma = (ea == 0) ? 0 : (32'h0080_0000 + a[22:0]);
        mb = (eb == 0) ? 0 : (32'h0080_0000 + b[22:0]);
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        if (a_big) begin
            el = ea; ml = ma; sl = a[31]; es = eb; ms = mb;
        end else begin
            el = eb; ml = mb; sl = b[31]; es = ea; ms = ma;
        end
        diff = el - es;
        al = (diff >= 24) ? 0 : ms / (32'd1 << diff);
        val = (a[31] != b[31]) ? ml - al : ml + al;
        r.man = val[24:0];
        if (val == 0) begin
            r.exp = 8'd0;
            r.sign = 1'b0;
        end else begin
            r.exp = el[7:0];
            r.sign = sl;
        end
        return r;
    endfunction

    task automatic test_reset();
        resetN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({outValid, sumMantissa, sumExp, sumSign, shiftRight} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0",
                     {outValid, sumMantissa, sumExp, sumSign, shiftRight});
        end
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_inready: got %b want 1", inReady);
        end
    endtask

    task automatic test_directed();
        vec_t v[11];
        res_t r;
        v[0]  = '{32'h3F80_0000, 32'h3F80_0000, 25'h100_0000, 8'd127, 1'b0};
        v[1]  = '{32'h4040_0000, 32'hBF80_0000, 25'h080_0000, 8'd128, 1'b0};
        v[2]  = '{32'h3FC0_0000, 32'hBFC0_0000, 25'h000_0000, 8'd0,   1'b0};
        v[3]  = '{32'h3F80_0000, 32'h3080_0000, 25'h080_0000, 8'd127, 1'b0};
        v[4]  = '{32'h3080_0000, 32'h3F80_0000, 25'h080_0000, 8'd127, 1'b0};
        v[5]  = '{32'h3F80_0000, 32'hC040_0000, 25'h080_0000, 8'd128, 1'b1};
        v[6]  = '{32'h0000_0001, 32'h3F80_0000, 25'h080_0000, 8'd127, 1'b0};
        v[7]  = '{32'hBFC0_0000, 32'h3FC0_0000, 25'h000_0000, 8'd0,   1'b0};
        v[8]  = '{32'h3F80_0000, 32'h3F00_0001, 25'h0C0_0000, 8'd127, 1'b0};
        v[9]  = '{32'h3F80_0000, 32'hBF00_0001, 25'h040_0000, 8'd127, 1'b0};
        v[10] = '{32'h7F80_0000, 32'h7F80_0000, 25'h100_0000, 8'd255, 1'b0};
        for (int i = 0; i < 11; i++) begin
            aIn = v[i].a;
            bIn = v[i].b;
            inValid = 1'b1;
            outReady = 1'b1;
            @(negedge clock);
            checks++;
            if (inReady !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_inready: got %b want 1", i, inReady);
            end
            @(posedge clock);
            #1;
            inValid = 1'b0;
            @(negedge clock);
            checks++;
            if (outValid !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_early_valid: got %b want 0", i, outValid);
            end
            @(posedge clock);
            #1;
            @(negedge clock);
            checks++;
            if ({outValid, sumMantissa, sumExp, sumSign, shiftRight} !==
                {1'b1, v[i].man, v[i].e, v[i].s, v[i].man[24]}) begin
                failures++;
                $display("FAIL dir%0d_result: got v=%b m=%h e=%0d s=%b sr=%b want m=%h e=%0d s=%b",
                         i, outValid, sumMantissa, sumExp, sumSign, shiftRight,
                         v[i].man, v[i].e, v[i].s);
            end
            r = ref_add(v[i].a, v[i].b);
            checks++;
            if ({sumMantissa, sumExp, sumSign} !== {r.man, r.exp, r.sign}) begin
                failures++;
                $display("FAIL dir%0d_model: got m=%h e=%0d s=%b want m=%h e=%0d s=%b",
                         i, sumMantissa, sumExp, sumSign, r.man, r.exp, r.sign);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // Stream of ops; rand_rdy picks random outReady, else outReady is low in cycles 3-5.
    task automatic test_stream(input bit rand_rdy, input int n);
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [35:0] hold_vals;
        bit          hold_v;
        bit          exp_ready;
        int          sent, got, cyc, limit;
        res_t        r;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(1, 0) == 1) b[30:23] = a[30:23] + 8'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0) b[30:0] = a[30:0];
            qa.push_back(a);
            qb.push_back(b);
        end
        sent = 0;
        got = 0;
        cyc = 1;
        hold_v = 1'b0;
        hold_vals = '0;
        limit = n * 10 + 50;
        sb.delete();
        while (got < n && cyc < limit) begin
            outReady = rand_rdy ? ($urandom_range(3, 0) != 0) : !(cyc >= 3 && cyc <= 5);
            inValid = (sent < n);
            aIn = (sent < n) ? qa[sent] : 32'h0;
            bIn = (sent < n) ? qb[sent] : 32'h0;
            @(negedge clock);
            exp_ready = !(sb.size() == 2 && !outReady);
            checks++;
            if (inReady !== exp_ready) begin
                failures++;
                $display("FAIL stream_inready cyc%0d: got %b want %b", cyc, inReady, exp_ready);
            end
            if (sb.size() == 0) begin
                checks++;
                if (outValid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_spurious_valid cyc%0d: got %b want 0", cyc, outValid);
                end
            end
            if (hold_v) begin
                checks++;
                if ({outValid, sumMantissa, sumExp, sumSign, shiftRight} !== hold_vals) begin
                    failures++;
                    $display("FAIL stream_hold cyc%0d: got %h want %h", cyc,
                             {outValid, sumMantissa, sumExp, sumSign, shiftRight}, hold_vals);
                end
            end
            if (outValid === 1'b1 && outReady) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra_result cyc%0d: got m=%h want none", cyc, sumMantissa);
                end else begin
                    r = sb.pop_front();
                    if ({sumMantissa, sumExp, sumSign, shiftRight} !==
                        {r.man, r.exp, r.sign, r.man[24]}) begin
                        failures++;
                        $display("FAIL stream_result #%0d: got m=%h e=%0d s=%b sr=%b want m=%h e=%0d s=%b",
                                 got, sumMantissa, sumExp, sumSign, shiftRight, r.man, r.exp, r.sign);
                    end
                end
                got++;
            end
            if (inValid && inReady === 1'b1) begin
                sb.push_back(ref_add(aIn, bIn));
                sent++;
            end
            hold_v = (outValid === 1'b1) && !outReady;
            hold_vals = {outValid, sumMantissa, sumExp, sumSign, shiftRight};
            @(posedge clock);
            #1;
            cyc++;
        end
        inValid = 1'b0;
        checks++;
        if (got != n || sb.size() != 0) begin
            failures++;
            $display("FAIL stream_complete: got %0d results want %0d (pending %0d)", got, n, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        outReady = 1'b0;
        inValid = 1'b1;
        aIn = 32'h3F80_0000;
        bIn = 32'h3F80_0000;
        @(posedge clock);
        #1;
        aIn = 32'h4040_0000;
        bIn = 32'hBF80_0000;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        @(negedge clock);
        checks++;
        if ({outValid, inReady} !== 2'b10) begin
            failures++;
            $display("FAIL midflight_full: got valid=%b ready=%b want valid=1 ready=0",
                     outValid, inReady);
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({outValid, sumMantissa, sumExp, sumSign, shiftRight} !== 36'h0) begin
            failures++;
            $display("FAIL midflight_async_clear: got %h want 0",
                     {outValid, sumMantissa, sumExp, sumSign, shiftRight});
        end
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("FAIL midflight_inready: got %b want 1", inReady);
        end
        outReady = 1'b1;
        inValid = 1'b1;
        aIn = 32'h4040_0000;
        bIn = 32'hBF80_0000;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_early_valid: got %b want 0", outValid);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({outValid, sumMantissa, sumExp, sumSign} !== {1'b1, 25'h080_0000, 8'd128, 1'b0}) begin
            failures++;
            $display("FAIL midflight_next_op: got v=%b m=%h e=%0d s=%b want v=1 m=0800000 e=128 s=0",
                     outValid, sumMantissa, sumExp, sumSign);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(1'b0, 5);
        test_stream(1'b1, 300);
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
